// File: rtl/vga_pkg.sv
// Shared types and constants for the video RAM loader.
// Grid geometry defaults, FSM state and byte type.
package vga_pkg;

  localparam int unsigned GRID_W = 32;
  localparam int unsigned GRID_H = 24;
  localparam int unsigned PIX_N  = GRID_W * GRID_H;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/vga_wr_ptr.sv
// Raster cell pointer for the video RAM write port.
// Clears on demand, steps on enable, wraps after the last cell.
module vga_wr_ptr #(
  parameter int unsigned N      = 768,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              at_last_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Clear wins over increment; the last cell wraps to zero.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o     = ptr_q;
  assign at_last_o = (ptr_q == LAST);

endmodule

// File: rtl/vga_ram_loader.sv
// Byte-stream writer for the 1-bit video RAM.
// Serialises bytes MSB-first into raster-ordered cell writes.
module vga_ram_loader
  import vga_pkg::*;
#(
  parameter int unsigned GRID_W = vga_pkg::GRID_W,
  parameter int unsigned GRID_H = vga_pkg::GRID_H,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              frame_start,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned N = GRID_W * GRID_H;

  state_e      state_q;
  byte_t       shreg_q;
  logic [2:0]  bit_cnt_q;
  logic        last_bit;
  logic        hs;
  logic        at_last;
  logic [ADDR_W-1:0] ptr;

  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == 3'd7);
  assign in_ready = (state_q == IDLE) || last_bit;
  assign hs       = in_valid && in_ready;

  vga_wr_ptr #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (frame_start),
    .inc_i     (state_q == SHIFT),
    .ptr_o     (ptr),
    .at_last_o (at_last)
  );

  // FSM: load on handshake, shift one bit per cycle, abort on frame_start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            shreg_q   <= in_data;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_q <= '0;
            if (hs) begin
              shreg_q <= in_data;
            end else begin
              shreg_q <= {shreg_q[6:0], 1'b0};
              state_q <= IDLE;
            end
          end else if (frame_start) begin
            bit_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            shreg_q   <= {shreg_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q == SHIFT);
  assign write_enable = busy;
  assign write_addr   = ptr;
  assign write_data   = busy && shreg_q[7];
  assign frame_done   = busy && at_last;

endmodule

// File: doc/vga_ram_loader.md
# vga_ram_loader

Byte-stream writer for the 1-bit video RAM inside `vga_ram_display`. It accepts bytes over a valid/ready handshake and serialises each byte MSB-first into single-bit RAM writes. Each write goes to a raster-ordered cell pointer that wraps once per frame. It sits between the host-side data source and the write port of the video RAM, and drives that port's `write_enable`/`write_data` pair plus a cell address.

## Interface
- `GRID_W`, default 32: cells per row.
- `GRID_H`, default 24: rows per frame.
- `ADDR_W`, default 10: width of the cell address; must satisfy 2^ADDR_W ≥ GRID_W*GRID_H.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `in_valid`  in  1  source presents a byte.
- `in_data`  in  8  byte; bit 7 is written first.
- `in_ready`  out  1  loader can take a byte this cycle.
- `frame_start`  in  1  single-cycle pulse; rewinds pointer to cell 0.
- `write_enable`  out  1  RAM write strobe, one bit per cycle.
- `write_addr`  out  ADDR_W  cell address; `y*GRID_W + x`.
- `write_data`  out  1  pixel bit.
- `frame_done`  out  1  high during the write to the last cell, N-1.
- `busy`  out  1  byte serialisation in progress.

## Operation
- N = GRID_W*GRID_H (768 by default). Pointer range is 0..N-1.
- FSM has two states, IDLE and SHIFT. It holds an 8-bit shift register, a 3-bit `bit_cnt` and the cell pointer `ptr`.
- IDLE:
  - `in_ready`=1.
  - Handshake (`in_valid && in_ready`) loads `in_data`, sets `bit_cnt`=0 and moves to SHIFT.
- SHIFT, each cycle:
  - Outputs: `write_enable`=1, `write_data`=shreg[7], `write_addr`=`ptr`.
  - Next-cycle update: shreg shifts left, `bit_cnt`+1, `ptr`+1.
- Pointer wrap: `ptr`==N-1 advances to 0. Bytes may straddle the wrap; the remaining bits continue at cell 0.
- Last bit (`bit_cnt`==7):
  - `in_ready`=1.
  - With a handshake, the new byte loads and the FSM stays in SHIFT, so the stream has no gap.
  - Without a handshake, the FSM returns to IDLE.
- `in_ready`=0 in SHIFT while `bit_cnt`<7.
- `frame_start`:
  - Next `ptr`=0.
  - In SHIFT with `bit_cnt`<7, the remaining bits of the current byte are discarded and the FSM goes to IDLE.
  - If a handshake occurs in the same cycle (IDLE or `bit_cnt`==7), the byte is accepted and its first bit lands at cell 0.
  - The write presented in the `frame_start` cycle itself still occurs.
- `frame_done` = `write_enable && ptr==N-1`.
- `busy` = state==SHIFT.
- All outputs decode from flops only; no combinational path from `in_valid`/`in_data`/`frame_start` to any output.

## Timing
- Reset values: state IDLE, `ptr`=0, `bit_cnt`=0, shreg=0. Outputs: `write_enable`=0, `write_addr`=0, `write_data`=0, `in_ready`=1, `frame_done`=0, `busy`=0.
- Latency: handshake at edge k puts bit 7 on the write port during cycle k+1. Bits 7..0 occupy cycles k+1..k+8.
- Throughput: with `in_valid` held, one byte per 8 cycles.
- Reset overrides everything. `rst_n` low during SHIFT gives reset values on the following cycle, and no further writes from the interrupted byte.
- `frame_start` together with `ptr`==N-1: pointer goes to 0 (same result as wrap); `frame_done` still asserts for that write.

## Structure
- Shared package `vga_pkg`:
  - `GRID_W`/`GRID_H` defaults.
  - Pixel-count constant.
  - FSM state typedef (IDLE, SHIFT).
  - 8-bit byte typedef.
- One sub-module, `vga_wr_ptr`: cell counter with synchronous clear, increment enable and wrap at N-1. It outputs `ptr` and `at_last`.
- The top module holds the FSM, shift register, `bit_cnt` and handshake.

## Test plan
- Reset, no stimulus → `in_ready`=1; `write_enable`/`write_addr`/`write_data`/`frame_done`/`busy`=0 for 20 cycles.
- Single byte 0xA5 after reset → writes addr 0..7 with data 1,0,1,0,0,1,0,1 on cycles k+1..k+8. `in_ready`=0 on k+1..k+7 and 1 on k+8; `busy` drops at k+9.
- Back-to-back 0xF0,0x0F with `in_valid` held → 16 consecutive write cycles, addr 0..15, data 1111000000001111, no idle cycle.
- Stream 96×0xFF then 0x80 → `frame_done` high exactly one cycle, at addr 767. The 97th byte writes addr 0..7 with data 1,0,0,0,0,0,0,0.
- `frame_start` 3 bits into 0xFF → 4 writes total (addr 0..3, including the write in the `frame_start` cycle), then `write_enable`=0. Next byte 0x01 writes addr 0..7 ending in data 1.
- `rst_n` low for 1 cycle during bit 4 of a byte at addr 100 → next cycle `write_enable`=0, `write_addr`=0, `in_ready`=1. Next byte starts at addr 0.
